// File: rtl/gelato_fetch_skd_if.sv
// Fetch request channel between the warp fetch scheduler and the instruction fetch stage.
// The scheduler drives the request on the master side; downstream answers with fetch_ready.
interface gelato_fetch_skd_if #(
    parameter int WARP_NUM  = 4,
    parameter int PC_WIDTH  = 32,
    parameter int STN_WIDTH = 5
);
    logic                        fetch_valid;
    logic                        fetch_ready;
    logic [PC_WIDTH-1:0]         fetch_pc;
    logic [$clog2(WARP_NUM)-1:0] fetch_warp_num;
    logic [STN_WIDTH-1:0]        fetch_split_table_num;

    modport master (
        output fetch_valid,
        output fetch_pc,
        output fetch_warp_num,
        output fetch_split_table_num,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        input  fetch_warp_num,
        input  fetch_split_table_num,
        output fetch_ready
    );
endinterface

// File: rtl/gelato_fetch_skd.sv
// Round-robin warp fetch scheduler with a single registered request slot and per-warp in-flight tracking.
// Optional performance counters are built when GELATO_FETCH_SKD_PERF_EN is defined.
module gelato_fetch_skd #(
    parameter int WARP_NUM  = 4,
    parameter int PC_WIDTH  = 32,
    parameter int STN_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rdy,
    input  logic [WARP_NUM-1:0]           pc_valid,
    input  logic [WARP_NUM*PC_WIDTH-1:0]  pc,
    input  logic [WARP_NUM*STN_WIDTH-1:0] split_table_num,
    gelato_fetch_skd_if.master            fetch,
    input  logic                          done_valid,
    input  logic [$clog2(WARP_NUM)-1:0]   done_warp_num,
    output logic [WARP_NUM-1:0]           inflight,
    output logic [31:0]                   perf_issue_cnt,
    output logic [31:0]                   perf_stall_cnt
);
    localparam int WN_W = $clog2(WARP_NUM);

    logic                 vld_p1;
    logic [PC_WIDTH-1:0]  pc_p1;
    logic [WN_W-1:0]      warp_p1;
    logic [STN_WIDTH-1:0] stn_p1;
    logic [WARP_NUM-1:0]  inflight_q;
    logic [WN_W-1:0]      rr_ptr;

    logic [WARP_NUM-1:0]  eligible;
    logic [WN_W-1:0]      sel;
    logic                 any_elig;
    logic [PC_WIDTH-1:0]  pc_sel;
    logic [STN_WIDTH-1:0] stn_sel;
    logic [WN_W-1:0]      idx;
    logic                 hs;
    logic                 load;
    logic [WARP_NUM-1:0]  done_mask;
    logic [WARP_NUM-1:0]  set_mask;
    logic [WARP_NUM-1:0]  inflight_nxt;

    assign eligible = pc_valid & ~inflight_q;

    // Stage p0: round-robin pick; scanning downwards lets the nearest warp to rr_ptr win.
    always_comb begin
        sel      = '0;
        any_elig = 1'b0;
        pc_sel   = '0;
        stn_sel  = '0;
        idx      = '0;
        for (int k = WARP_NUM - 1; k >= 0; k--) begin
            idx = rr_ptr + WN_W'(k);
            if (eligible[idx]) begin
                sel      = idx;
                any_elig = 1'b1;
                pc_sel   = pc[idx*PC_WIDTH +: PC_WIDTH];
                stn_sel  = split_table_num[idx*STN_WIDTH +: STN_WIDTH];
            end
        end
    end

    assign hs   = vld_p1 & fetch.fetch_ready;
    assign load = rdy & (~vld_p1 | fetch.fetch_ready) & any_elig;

    // A warp being set is never in flight, so set and clear never fight over one bit.
    always_comb begin
        done_mask = '0;
        set_mask  = '0;
        if (done_valid) begin
            done_mask[done_warp_num] = 1'b1;
        end
        if (load) begin
            set_mask[sel] = 1'b1;
        end
        inflight_nxt = (inflight_q & ~done_mask) | set_mask;
    end

    // Stage p1: output request slot, in-flight mask and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            warp_p1    <= '0;
            stn_p1     <= '0;
            inflight_q <= '0;
            rr_ptr     <= '0;
        end else if (rdy) begin
            inflight_q <= inflight_nxt;
            if (load) begin
                vld_p1  <= 1'b1;
                pc_p1   <= pc_sel;
                warp_p1 <= sel;
                stn_p1  <= stn_sel;
                rr_ptr  <= sel + WN_W'(1);
            end else if (hs) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign fetch.fetch_valid           = vld_p1;
    assign fetch.fetch_pc              = pc_p1;
    assign fetch.fetch_warp_num        = warp_p1;
    assign fetch.fetch_split_table_num = stn_p1;
    assign inflight                    = inflight_q;

`ifdef GELATO_FETCH_SKD_PERF_EN
    logic [31:0] issue_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (rdy) begin
            if (hs) begin
                issue_cnt_q <= issue_cnt_q + 32'd1;
            end
            if (vld_p1 && !fetch.fetch_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = issue_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_issue_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif
endmodule
